// File: rtl/npu_operand_feeder.sv
// npu_operand_feeder: stages one NxN A matrix (by row) and one NxN B matrix (by column) and
// replays them as a skewed diagonal wavefront. Define NPU_FEEDER_ACCCLR_EN to add the acc_clr_o port.
module npu_operand_feeder #(
   parameter  int N  = 2,
   parameter  int DW = 8,
   localparam int IW = $clog2(N),
   localparam int CW = $clog2(2 * N)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            wr_valid_i,
   output logic            wr_ready_o,
   input  logic            wr_sel_i,
   input  logic [IW-1:0]   wr_idx_i,
   input  logic [N*DW-1:0] wr_data_i,
   input  logic            start_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [N*DW-1:0] a_out_o,
   output logic [N*DW-1:0] b_out_o,
   output logic [N-1:0]    a_vld_o,
   output logic [N-1:0]    b_vld_o
`ifdef NPU_FEEDER_ACCCLR_EN
   ,
   output logic            acc_clr_o
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } state_e;

   // The step counter runs one value past the last wavefront step; that extra value
   // produces the all-zero DONE beat so outputs stay one register behind the FSM.
   localparam logic [CW-1:0] LAST_STEP = CW'(2 * N - 1);

   state_e          stateQ, stateD;
   logic [CW-1:0]   stepQ, stepD;

   logic [DW-1:0]   aBufQ [N][N];
   logic [DW-1:0]   bBufQ [N][N];

   logic [N*DW-1:0] aOutQ, aOutD;
   logic [N*DW-1:0] bOutQ, bOutD;
   logic [N-1:0]    aVldQ, aVldD;
   logic [N-1:0]    bVldQ, bVldD;
   logic            busyQ, busyD;
   logic            doneQ, doneD;
   logic            wrFire;
   int              diag;

   assign wr_ready_o = (stateQ == IDLE);
   assign wrFire     = wr_valid_i && wr_ready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stateQ <= IDLE;
         stepQ  <= '0;
      end else begin
         stateQ <= stateD;
         stepQ  <= stepD;
      end
   end

   always_comb begin
      stateD = stateQ;
      stepD  = stepQ;
      unique case (stateQ)
         IDLE: begin
            if (start_i) begin
               stateD = STREAM;
               stepD  = '0;
            end
         end
         STREAM: begin
            if (stepQ == LAST_STEP) begin
               stateD = DONE;
            end else begin
               stepD = stepQ + CW'(1);
            end
         end
         DONE: begin
            stateD = IDLE;
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   // B is stored as B[row][col]; a column write scatters element k into row k.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               aBufQ[r][c] <= '0;
               bBufQ[r][c] <= '0;
            end
         end
      end else if (wrFire && (int'(wr_idx_i) < N)) begin
         for (int k = 0; k < N; k++) begin
            if (!wr_sel_i) begin
               aBufQ[wr_idx_i][k] <= wr_data_i[k*DW +: DW];
            end else begin
               bBufQ[k][wr_idx_i] <= wr_data_i[k*DW +: DW];
            end
         end
      end
   end

   // Lane i carries element (step - i) of its row/column while that index lies inside the matrix.
   always_comb begin
      aOutD = '0;
      bOutD = '0;
      aVldD = '0;
      bVldD = '0;
      diag  = 0;
      busyD = (stateQ == STREAM);
      doneD = (stateQ == STREAM) && (stepQ == LAST_STEP);
      if (stateQ == STREAM) begin
         for (int i = 0; i < N; i++) begin
            diag = int'(stepQ) - i;
            if ((diag >= 0) && (diag < N)) begin
               aOutD[i*DW +: DW] = aBufQ[i][diag[IW-1:0]];
               bOutD[i*DW +: DW] = bBufQ[diag[IW-1:0]][i];
               aVldD[i]          = 1'b1;
               bVldD[i]          = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         aOutQ <= '0;
         bOutQ <= '0;
         aVldQ <= '0;
         bVldQ <= '0;
         busyQ <= 1'b0;
         doneQ <= 1'b0;
      end else begin
         aOutQ <= aOutD;
         bOutQ <= bOutD;
         aVldQ <= aVldD;
         bVldQ <= bVldD;
         busyQ <= busyD;
         doneQ <= doneD;
      end
   end

   assign a_out_o = aOutQ;
   assign b_out_o = bOutQ;
   assign a_vld_o = aVldQ;
   assign b_vld_o = bVldQ;
   assign busy_o  = busyQ;
   assign done_o  = doneQ;

`ifdef NPU_FEEDER_ACCCLR_EN
   // Pulses alongside step 0 so downstream MACs zero before their first product.
   logic accClrQ, accClrD;

   assign accClrD = (stateQ == STREAM) && (stepQ == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         accClrQ <= 1'b0;
      end else begin
         accClrQ <= accClrD;
      end
   end

   assign acc_clr_o = accClrQ;
`endif

endmodule

// File: tb/tb_npu_operand_feeder.sv
// tb_npu_operand_feeder: directed and randomized checks of npu_operand_feeder against a
// matrix-level model of the skewed wavefront. Optional acc_clr checks follow NPU_FEEDER_ACCCLR_EN.
module tb_npu_operand_feeder;

   localparam int N  = 3;
   localparam int DW = 8;
   localparam int IW = $clog2(N);
   localparam int W  = N * DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_valid;
   logic          wr_ready;
   logic          wr_sel;
   logic [IW-1:0] wr_idx;
   logic [W-1:0]  wr_data;
   logic          start;
   logic          busy;
   logic          done;
   logic [W-1:0]  a_out;
   logic [W-1:0]  b_out;
   logic [N-1:0]  a_vld;
   logic [N-1:0]  b_vld;
`ifdef NPU_FEEDER_ACCCLR_EN
   logic          acc_clr;
`endif

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] mA [N][N];
   logic [DW-1:0] mB [N][N];

   npu_operand_feeder #(.N(N), .DW(DW)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .wr_valid_i (wr_valid),
      .wr_ready_o (wr_ready),
      .wr_sel_i   (wr_sel),
      .wr_idx_i   (wr_idx),
      .wr_data_i  (wr_data),
      .start_i    (start),
      .busy_o     (busy),
      .done_o     (done),
      .a_out_o    (a_out),
      .b_out_o    (b_out),
      .a_vld_o    (a_vld),
      .b_vld_o    (b_vld)
`ifdef NPU_FEEDER_ACCCLR_EN
      ,
      .acc_clr_o  (acc_clr)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] expA(input int t);
      logic [W-1:0] r = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N) r[i*DW +: DW] = mA[i][t-i];
      return r;
   endfunction

   function automatic logic [W-1:0] expB(input int t);
      logic [W-1:0] r = '0;
      for (int j = 0; j < N; j++)
         if (t - j >= 0 && t - j < N) r[j*DW +: DW] = mB[t-j][j];
      return r;
   endfunction

   function automatic logic [N-1:0] expVld(input int t);
      logic [N-1:0] r = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N) r[i] = 1'b1;
      return r;
   endfunction

   task automatic clearModel();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            mA[r][c] = '0;
            mB[r][c] = '0;
         end
   endtask

   task automatic modelWrite(input logic sel, input int idx, input logic [W-1:0] data);
      if (idx < N)
         for (int k = 0; k < N; k++)
            if (!sel) mA[idx][k] = data[k*DW +: DW];
            else      mB[k][idx] = data[k*DW +: DW];
   endtask

   // One write beat issued from IDLE; indices >= N must be swallowed without effect.
   task automatic applyStimulus(input logic sel, input int idx, input logic [W-1:0] data);
      wr_valid = 1'b1;
      wr_sel   = sel;
      wr_idx   = IW'(idx);
      wr_data  = data;
      checkOutput("wr_ready_idle", 64'(wr_ready), 64'd1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      modelWrite(sel, idx, data);
   endtask

   task automatic runStream(input bit holdWr, input bit pokeStart);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (holdWr) begin
         wr_valid = 1'b1;
         wr_sel   = 1'($urandom);
         wr_idx   = IW'($urandom_range(N - 1, 0));
         wr_data  = W'($urandom);
      end else begin
         wr_valid = 1'b0;
      end
      checkOutput("busy_at_e0", 64'(busy), 64'd0);
      checkOutput("wr_ready_stream", 64'(wr_ready), 64'd0);
      for (int t = 0; t <= 2 * N - 2; t++) begin
         start = (pokeStart && t == 1);
         @(posedge clk); #1;
         checkOutput($sformatf("a_out_t%0d", t), 64'(a_out), 64'(expA(t)));
         checkOutput($sformatf("b_out_t%0d", t), 64'(b_out), 64'(expB(t)));
         checkOutput($sformatf("a_vld_t%0d", t), 64'(a_vld), 64'(expVld(t)));
         checkOutput($sformatf("b_vld_t%0d", t), 64'(b_vld), 64'(expVld(t)));
         checkOutput($sformatf("busy_t%0d", t), 64'(busy), 64'd1);
         checkOutput($sformatf("done_t%0d", t), 64'(done), 64'd0);
         if (holdWr) checkOutput("wr_ready_held", 64'(wr_ready), 64'd0);
`ifdef NPU_FEEDER_ACCCLR_EN
         checkOutput($sformatf("acc_clr_t%0d", t), 64'(acc_clr), 64'(t == 0));
`endif
      end
      start = 1'b0;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      checkOutput("done_pulse", 64'(done), 64'd1);
      checkOutput("done_outs", {a_out, b_out, a_vld, b_vld}, 64'd0);
      checkOutput("busy_done", 64'(busy), 64'd1);
`ifdef NPU_FEEDER_ACCCLR_EN
      checkOutput("acc_clr_done", 64'(acc_clr), 64'd0);
`endif
      @(posedge clk); #1;
      checkOutput("done_end", 64'(done), 64'd0);
      checkOutput("busy_end", 64'(busy), 64'd0);
      checkOutput("wr_ready_end", 64'(wr_ready), 64'd1);
      @(posedge clk); #1;
      checkOutput("idle_stays", 64'(busy), 64'd0);
   endtask

   initial begin
      bit sawDone;
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      wr_sel   = 1'b0;
      wr_idx   = '0;
      wr_data  = '0;
      start    = 1'b1;
      clearModel();

      // Reset state, with start held high while in reset.
      #2;
      checkOutput("rst_outs", {a_out, b_out, a_vld, b_vld}, 64'd0);
      checkOutput("rst_busy_done", {62'd0, busy, done}, 64'd0);
      checkOutput("rst_wr_ready", 64'(wr_ready), 64'd1);
      @(posedge clk); #1;
      checkOutput("rst_start_ignored", 64'(busy), 64'd0);
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] directed load and stream");
      applyStimulus(1'b0, 0, 24'h030201);
      applyStimulus(1'b0, 1, 24'h060504);
      applyStimulus(1'b0, 2, 24'h090807);
      applyStimulus(1'b1, 0, 24'h131211);
      applyStimulus(1'b1, 1, 24'h161514);
      applyStimulus(1'b1, 2, 24'h191817);
      applyStimulus(1'b0, 3, 24'hEEEEEE);
      runStream(1'b0, 1'b0);

      $display("[TB] write held during stream, start ignored while busy");
      runStream(1'b1, 1'b1);
      runStream(1'b0, 1'b0);

      $display("[TB] same-cycle write and start");
      wr_valid = 1'b1;
      wr_sel   = 1'b0;
      wr_idx   = '0;
      wr_data  = 24'h0A0909;
      modelWrite(1'b0, 0, 24'h0A0909);
      runStream(1'b0, 1'b0);

      $display("[TB] reset mid-stream");
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("pre_rst_a_t1", 64'(a_out), 64'(expA(1)));
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_outs", {a_out, b_out, a_vld, b_vld}, 64'd0);
      checkOutput("midrst_busy_done", {62'd0, busy, done}, 64'd0);
      checkOutput("midrst_wr_ready", 64'(wr_ready), 64'd1);
      clearModel();
      @(posedge clk); #1;
      rst_n   = 1'b1;
      sawDone = 1'b0;
      for (int c = 0; c < 2 * N + 2; c++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) sawDone = 1'b1;
      end
      checkOutput("midrst_no_done", 64'(sawDone), 64'd0);
      runStream(1'b0, 1'b0);

      $display("[TB] randomized loads");
      for (int r = 0; r < 4; r++) begin
         for (int w = 0; w < 6; w++)
            applyStimulus(1'($urandom), int'($urandom_range(N, 0)), W'($urandom));
         runStream(r[0], r[1]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
